c3demo_send_arbiter: RTL and testbench

- Round-robin arbiter that shares the RasPi send FIFO among NUM_EP byte-stream send endpoints.
- Replaces the fixed highest-index priority on the send path. It grants one endpoint at a time, for up to MAX_BURST bytes or until that endpoint marks a packet end, so no endpoint is starved.
- Sits between the endpoint producers and the send_valid/send_ready/send_tdata inputs of the RasPi interface, with the interface configured as a single endpoint stream plus out_epnum.

---
 rtl/c3demo_send_arbiter.sv | 118 +++++++++++
 tb/tb_c3demo_send_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/c3demo_send_arbiter.sv
// c3demo_send_arbiter: round-robin arbiter sharing one byte-stream send FIFO among
// NUM_EP endpoints, releasing on packet end, burst limit or producer stall.
module c3demo_send_arbiter #(
    parameter int NUM_EP    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_EP-1:0]   in_valid,
    output logic [NUM_EP-1:0]   in_ready,
    input  logic [8*NUM_EP-1:0] in_data,
    input  logic [NUM_EP-1:0]   in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic [7:0]          out_epnum,
    output logic                grant_active,
    output logic [2:0]          grant_ep
);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] burst_cnt;
    logic [2:0]    last_ep;
    logic          g_valid, g_last;
    logic [7:0]    g_data;
    logic          scan_found, hi_found;
    logic [2:0]    scan_ep, hi_ep, lo_ep;
    logic          xfer, release_grant;

    // Select the granted endpoint's stream.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (grant_ep == 3'(i)) begin
                g_valid = in_valid[i];
                g_last  = in_last[i];
                g_data  = in_data[8*i +: 8];
            end
        end
    end

    // Round-robin scan: lowest requester above last_ep, else lowest requester overall.
    always_comb begin
        scan_found = 1'b0;
        hi_found   = 1'b0;
        hi_ep      = '0;
        lo_ep      = '0;
        for (int i = NUM_EP - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                scan_found = 1'b1;
                lo_ep      = 3'(i);
                if (3'(i) > last_ep) begin
                    hi_found = 1'b1;
                    hi_ep    = 3'(i);
                end
            end
        end
        scan_ep = hi_found ? hi_ep : lo_ep;
    end

    assign xfer          = (state == GRANT) && g_valid && out_ready;
    assign release_grant = (state == GRANT) &&
                           (!g_valid || (xfer && (g_last || burst_cnt == CW'(MAX_BURST - 1))));

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (scan_found)    state_next = GRANT;
            GRANT:   if (release_grant) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        in_ready  = '0;
        out_epnum = {5'b0, grant_ep};
        // Gating with resetn guarantees no handshake completes in a reset cycle.
        if (resetn && state == GRANT) begin
            out_valid = g_valid;
            out_data  = g_data;
            for (int i = 0; i < NUM_EP; i++) begin
                if (grant_ep == 3'(i)) in_ready[i] = out_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            grant_active <= 1'b0;
            grant_ep     <= '0;
            burst_cnt    <= '0;
            last_ep      <= 3'(NUM_EP - 1);
        end else if (state == IDLE && scan_found) begin
            grant_ep     <= scan_ep;
            grant_active <= 1'b1;
            burst_cnt    <= '0;
        end else if (release_grant) begin
            last_ep      <= grant_ep;
            grant_active <= 1'b0;
        end else if (xfer) begin
            burst_cnt    <= burst_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_c3demo_send_arbiter.sv
// Directed bench for c3demo_send_arbiter: per-endpoint producer queues feed the DUT,
// and a per-endpoint expected-byte scoreboard is compared against every transfer.
module tb_c3demo_send_arbiter;
    localparam int NUM_EP    = 4;
    localparam int MAX_BURST = 16;

    logic                clk = 1'b0;
    logic                resetn;
    logic [NUM_EP-1:0]   in_valid, in_ready, in_last;
    logic [8*NUM_EP-1:0] in_data;
    logic                out_valid, out_ready;
    logic [7:0]          out_data, out_epnum;
    logic                grant_active;
    logic [2:0]          grant_ep;

    c3demo_send_arbiter #(.NUM_EP(NUM_EP), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_epnum(out_epnum),
        .grant_active(grant_active), .grant_ep(grant_ep)
    );

    always #5 clk = ~clk;

    logic [8:0]        src_q[NUM_EP][$];   // producer side: {last, data}
    logic [8:0]        exp_q[NUM_EP][$];   // scoreboard: bytes each endpoint must deliver
    logic [NUM_EP-1:0] hold;
    logic [2:0]        grant_log[$];
    logic              prev_ga = 1'b0;
    logic              ga_hist[0:80];
    int                xfer_cnt[NUM_EP];
    int                errors = 0, checks = 0, nxfer = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_EP; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                in_valid[i]       = 1'b1;
                in_data[8*i +: 8] = src_q[i][0][7:0];
                in_last[i]        = src_q[i][0][8];
            end else begin
                in_valid[i]       = 1'b0;
                in_data[8*i +: 8] = 8'h00;
                in_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic load(input int ep, input int n, input logic [7:0] base, input logic last);
        logic [8:0] w;
        for (int k = 0; k < n; k++) begin
            w = {last && (k == n - 1), base + 8'(k)};
            src_q[ep].push_back(w);
            exp_q[ep].push_back(w);
        end
    endtask

    task automatic new_test();
        grant_log.delete();
        for (int i = 0; i < NUM_EP; i++) xfer_cnt[i] = 0;
    endtask

    // One clock: observe at negedge, then retire accepted bytes and re-drive after posedge.
    task automatic step();
        logic [NUM_EP-1:0] hs, exp_ir;
        logic              gv;
        logic [8:0]        w;
        int                e;
        @(negedge clk);
        exp_ir = '0;
        gv     = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (grant_ep == 3'(i)) begin
                gv = in_valid[i];
                if (resetn && grant_active && out_ready) exp_ir[i] = 1'b1;
            end
        end
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        check("out_valid", 32'(out_valid), 32'(resetn && grant_active && gv));
        if (grant_active && !prev_ga) grant_log.push_back(grant_ep);
        prev_ga = grant_active;
        if (out_valid && out_ready) begin
            nxfer++;
            e = int'(out_epnum);
            check("out_epnum", 32'(out_epnum), 32'({5'b0, grant_ep}));
            if (e < NUM_EP && exp_q[e].size() > 0) begin
                w = exp_q[e].pop_front();
                xfer_cnt[e]++;
                check("out_data", 32'(out_data), 32'(w[7:0]));
            end else begin
                check("spurious_xfer_ep", 32'(out_epnum), 32'hFFFF_FFFF);
            end
        end
        hs = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_EP; i++)
            if (hs[i] && src_q[i].size() > 0) src_q[i].delete(0);
        drive();
    endtask

    task automatic run_quiet(input string tag, input int limit);
        int n = 0, busy, left;
        busy = 1;
        while (busy != 0 && n < limit) begin
            step();
            n++;
            busy = grant_active ? 1 : 0;
            for (int i = 0; i < NUM_EP; i++) if (src_q[i].size() > 0) busy = 1;
        end
        check({tag, "_done_in_time"}, 32'(n < limit), 32'd1);
        left = 0;
        for (int i = 0; i < NUM_EP; i++) left += exp_q[i].size();
        check({tag, "_drained"}, 32'(left), 32'd0);
    endtask

    task automatic reset_dut();
        resetn    = 1'b0;
        out_ready = 1'b1;
        hold      = '0;
        for (int i = 0; i < NUM_EP; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        drive();
        step();
        step();
        check("rst_grant_active", 32'(grant_active), 32'd0);
        check("rst_grant_ep", 32'(grant_ep), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        resetn = 1'b1;
        new_test();
    endtask

    initial begin
        int base;

        // Single requester: ep2 sends 0x10..0x14 with last on 0x14.
        reset_dut();
        load(2, 5, 8'h10, 1'b1);
        drive();
        check("t1_idle_first", 32'(grant_active), 32'd0);
        step();
        check("t1_grant_active", 32'(grant_active), 32'd1);
        check("t1_grant_ep", 32'(grant_ep), 32'd2);
        check("t1_out_epnum", 32'(out_epnum), 32'd2);
        base = nxfer;
        repeat (5) step();
        check("t1_xfers", 32'(nxfer - base), 32'd5);
        check("t1_released", 32'(grant_active), 32'd0);
        check("t1_drained", 32'(exp_q[2].size()), 32'd0);

        // Fairness: all four endpoints continuously valid, no packet ends.
        reset_dut();
        for (int e = 0; e < NUM_EP; e++) load(e, 32, 8'(e * 32), 1'b0);
        drive();
        base = nxfer;
        for (int k = 1; k <= 68; k++) begin
            step();
            ga_hist[k] = grant_active;
        end
        check("t2_bytes_68_cycles", 32'(nxfer - base), 32'd64);
        check("t2_burst_hold", 32'(ga_hist[16]), 32'd1);
        check("t2_bubble", 32'(ga_hist[17]), 32'd0);
        check("t2_next_grant", 32'(ga_hist[18]), 32'd1);
        check("t2_end_bubble", 32'(ga_hist[68]), 32'd0);
        check("t2_grant_count", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < grant_log.size()) check("t2_order", 32'(grant_log[k]), 32'(k));
            check("t2_burst_len", 32'(xfer_cnt[k]), 32'(MAX_BURST));
        end

        // Packet end: ep1 sends 3 bytes with last while ep3 waits.
        reset_dut();
        load(1, 3, 8'h30, 1'b1);
        load(3, 4, 8'h40, 1'b1);
        drive();
        step();
        check("t3_first_ep1", 32'(grant_ep), 32'd1);
        repeat (3) step();
        check("t3_released", 32'(grant_active), 32'd0);
        step();
        check("t3_ep3_active", 32'(grant_active), 32'd1);
        check("t3_ep3_grant", 32'(grant_ep), 32'd3);
        run_quiet("t3", 50);
        check("t3_ep1_bytes", 32'(xfer_cnt[1]), 32'd3);

        // Backpressure: ep0 stalled by out_ready for 10 cycles mid-burst.
        new_test();
        load(0, 18, 8'h50, 1'b0);
        drive();
        step();
        check("t4_grant_ep0", 32'(grant_ep), 32'd0);
        base = nxfer;
        repeat (3) step();
        check("t4_pre_stall", 32'(nxfer - base), 32'd3);
        out_ready = 1'b0;
        repeat (10) step();
        check("t4_stall_no_xfer", 32'(nxfer - base), 32'd3);
        check("t4_stall_held", 32'(grant_active), 32'd1);
        out_ready = 1'b1;
        repeat (12) step();
        check("t4_still_granted", 32'(grant_active), 32'd1);
        step();
        check("t4_burst_release", 32'(grant_active), 32'd0);
        check("t4_burst_bytes", 32'(nxfer - base), 32'd16);
        run_quiet("t4", 50);
        check("t4_regrant_count", 32'(grant_log.size()), 32'd2);

        // Producer stall: ep2 drops in_valid after 4 bytes while ep0 requests.
        new_test();
        load(2, 10, 8'h60, 1'b0);
        drive();
        step();
        check("t5_grant_ep2", 32'(grant_ep), 32'd2);
        repeat (4) step();
        hold[2] = 1'b1;
        load(0, 3, 8'h70, 1'b1);
        drive();
        step();
        check("t5_stall_release", 32'(grant_active), 32'd0);
        check("t5_ep2_bytes", 32'(xfer_cnt[2]), 32'd4);
        hold[2] = 1'b0;
        drive();
        step();
        check("t5_grant_ep0", 32'(grant_ep), 32'd0);
        run_quiet("t5", 100);
        check("t5_grant_count", 32'(grant_log.size()), 32'd3);
        if (grant_log.size() == 3) check("t5_regrant_ep2", 32'(grant_log[2]), 32'd2);

        // Reset mid-burst: resetn low while ep1's 7th byte is offered.
        new_test();
        load(1, 10, 8'h80, 1'b0);
        drive();
        step();
        check("t6_grant_ep1", 32'(grant_ep), 32'd1);
        repeat (6) step();
        resetn = 1'b0;
        load(0, 2, 8'h90, 1'b1);
        drive();
        base = nxfer;
        step();
        check("t6_no_xfer_in_reset", 32'(nxfer - base), 32'd0);
        check("t6_grant_dropped", 32'(grant_active), 32'd0);
        check("t6_in_ready_low", 32'(in_ready), 32'd0);
        check("t6_byte7_kept", 32'(src_q[1].size()), 32'd4);
        resetn = 1'b1;
        step();
        check("t6_post_reset_ep0", 32'(grant_ep), 32'd0);
        run_quiet("t6", 100);
        check("t6_ep1_total", 32'(xfer_cnt[1]), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
